stream_frame_sequencer: RTL

Sequencer that drives the raster coordinate stream (`vcnt`/`hcnt`) into the pooling/unpooling stream pipeline for a programmed number of frames. It qualifies active pixels and pooling-window completion points for a given pyramid `LEVEL`. After the last frame it keeps the coordinate stream running so in-flight pipeline data drains out, then reports completion. It sits between the layer-level controller (start/abort/done) and the head of a pooling layer chain.

---
 rtl/stream_frame_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/stream_frame_sequencer.sv
// Raster coordinate sequencer for a pooling stream pipeline: runs FRAMES frames,
// qualifies active pixels and pooling-window ends, then drains LATENCY cycles.
module stream_frame_sequencer #(
  parameter  int WIDTH    = 4,
  parameter  int HEIGHT   = 2,
  parameter  int W_WIDTH  = 6,
  parameter  int W_HEIGHT = 4,
  parameter  int LEVEL    = 0,
  parameter  int LATENCY  = 4,
  parameter  int FRAMES   = 2,
  localparam int V_BITW   = $clog2(W_HEIGHT),
  localparam int H_BITW   = $clog2(W_WIDTH),
  localparam int F_BITW   = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [V_BITW-1:0] out_vcnt,
  output logic [H_BITW-1:0] out_hcnt,
  output logic              out_active,
  output logic              out_pool_en,
  output logic              frame_start,
  output logic [F_BITW-1:0] frame_idx,
  output logic [1:0]        dbg_state
);

  // Handshake: start is a level request honoured only in IDLE (abort wins);
  // busy covers RUN+DRAIN, and done pulses for one cycle after the drain.

  localparam int D_BITW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [V_BITW-1:0] V_LAST = V_BITW'(W_HEIGHT - 1);
  localparam logic [H_BITW-1:0] H_LAST = H_BITW'(W_WIDTH - 1);
  localparam logic [F_BITW-1:0] F_LAST = F_BITW'(FRAMES - 1);
  localparam logic [D_BITW-1:0] D_LAST = D_BITW'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [V_BITW-1:0]   vcnt_q, vcnt_d, vcnt_adv;
  logic [H_BITW-1:0]   hcnt_q, hcnt_d, hcnt_adv;
  logic [F_BITW-1:0]   frame_q, frame_d;
  logic [D_BITW-1:0]   drain_q, drain_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                active_q, active_d;
  logic                pool_q, pool_d;
  logic                fstart_q, fstart_d;
  logic                h_last, v_last;

  always_comb begin
    h_last   = (hcnt_q == H_LAST);
    v_last   = (vcnt_q == V_LAST);
    hcnt_adv = h_last ? '0 : hcnt_q + H_BITW'(1);
    vcnt_adv = vcnt_q;
    if (h_last) begin
      vcnt_adv = v_last ? '0 : vcnt_q + V_BITW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    vcnt_d  = vcnt_q;
    hcnt_d  = hcnt_q;
    frame_d = frame_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        vcnt_d  = '0;
        hcnt_d  = '0;
        frame_d = '0;
        drain_d = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        vcnt_d = vcnt_adv;
        hcnt_d = hcnt_adv;
        if (h_last && v_last) begin
          if (frame_q == F_LAST) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            frame_d = frame_q + F_BITW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Coordinates keep moving so downstream line buffers flush.
        vcnt_d = vcnt_adv;
        hcnt_d = hcnt_adv;
        if (drain_q == D_LAST) begin
          state_d = S_DONE;
          vcnt_d  = '0;
          hcnt_d  = '0;
          frame_d = '0;
        end else begin
          drain_d = drain_q + D_BITW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        vcnt_d  = '0;
        hcnt_d  = '0;
        frame_d = '0;
        drain_d = '0;
      end
    endcase
    if (abort) begin
      state_d = S_IDLE;
      vcnt_d  = '0;
      hcnt_d  = '0;
      frame_d = '0;
      drain_d = '0;
    end
  end

  // Output flags are computed from next-state values so every port is a flop.
  always_comb begin
    busy_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d   = (state_d == S_DONE);
    active_d = (state_d == S_RUN)
               && ({1'b0, vcnt_d} < (V_BITW + 1)'(HEIGHT))
               && ({1'b0, hcnt_d} < (H_BITW + 1)'(WIDTH));
    pool_d   = active_d && (&vcnt_d[LEVEL:0]) && (&hcnt_d[LEVEL:0]);
    fstart_d = (state_d == S_RUN) && (vcnt_d == '0) && (hcnt_d == '0);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vcnt_q   <= '0;
      hcnt_q   <= '0;
      frame_q  <= '0;
      drain_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      active_q <= 1'b0;
      pool_q   <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vcnt_q   <= vcnt_d;
      hcnt_q   <= hcnt_d;
      frame_q  <= frame_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      active_q <= active_d;
      pool_q   <= pool_d;
      fstart_q <= fstart_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign out_vcnt    = vcnt_q;
  assign out_hcnt    = hcnt_q;
  assign out_active  = active_q;
  assign out_pool_en = pool_q;
  assign frame_start = fstart_q;
  assign frame_idx   = frame_q;
  assign dbg_state   = state_q;

endmodule
